// File: rtl/regfile_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_seq_ctrl_pkg
// Description : Shared opcodes, sequencer state encoding and instruction
//               field positions for the register-file sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_seq_ctrl_pkg;

    localparam int INSTR_W = 12;

    // Instruction field bit positions
    localparam int OP_HI  = 11;
    localparam int OP_LO  = 10;
    localparam int RD_HI  = 9;
    localparam int RD_LO  = 7;
    localparam int RA_HI  = 6;
    localparam int RA_LO  = 4;
    localparam int RB_HI  = 2;
    localparam int RB_LO  = 0;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = 4;

    // Opcodes
    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_MOV = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    // ADD and SUB are the only opcodes that produce a meaningful carry/borrow
    function automatic logic is_arith(input logic [1:0] op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_seq_ctrl_if
// Description : Instruction handshake plus register-file read/write bus of
//               the sequencer. The master side issues instructions and owns
//               the register file; the slave side is the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_seq_ctrl_if #(
    parameter int DW = 4,
    parameter int AW = 3
);
    import regfile_seq_ctrl_pkg::*;

    logic               start;
    logic [INSTR_W-1:0] instr;
    logic               busy;
    logic               done;
    logic [AW-1:0]      rp;
    logic [AW-1:0]      rq;
    logic [DW-1:0]      datap;
    logic [DW-1:0]      dataq;
    logic [AW-1:0]      wa;
    logic               wr;
    logic [DW-1:0]      ld_data;
    logic               carry;
    logic               zero;

    modport master (
        output start, instr, datap, dataq,
        input  busy, done, rp, rq, wa, wr, ld_data, carry, zero
    );

    modport slave (
        input  start, instr, datap, dataq,
        output busy, done, rp, rq, wa, wr, ld_data, carry, zero
    );

endinterface
`default_nettype wire

// File: rtl/regfile_seq_ctrl_alu.sv
`default_nettype none
// ============================================================================
// Module      : rfs_alu
// Description : Combinational ALU of the register-file sequencer. Produces a
//               DW+1 bit result whose top bit is carry (ADD) or borrow (SUB).
// Revision    : 1.0 - initial release
// ============================================================================
module rfs_alu
    import regfile_seq_ctrl_pkg::*;
#(
    parameter int DW = 4
) (
    input  wire logic [1:0]       op,
    input  wire logic [DW-1:0]    op_p,
    input  wire logic [DW-1:0]    op_q,
    input  wire logic [IMM_W-1:0] imm,
    output logic      [DW:0]      result
);

    logic [DW-1:0] w_imm;

    assign w_imm = DW'(imm);

    // Zero-extending both operands makes bit DW the carry for ADD and the
    // borrow (op_p < op_q) for SUB.
    always_comb begin
        result = '0;
        unique case (op)
            OP_LDI: result = {1'b0, w_imm};
            OP_MOV: result = {1'b0, op_p};
            OP_ADD: result = {1'b0, op_p} + {1'b0, op_q};
            OP_SUB: result = {1'b0, op_p} - {1'b0, op_q};
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/regfile_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_seq_ctrl
// Description : Four-cycle sequencer executing one LDI/MOV/ADD/SUB at a time
//               against an external dual-read, single-write register file,
//               with CARRY and ZERO status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_seq_ctrl
    import regfile_seq_ctrl_pkg::*;
#(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    regfile_seq_ctrl_if.slave  bus
);

    state_t             r_state;
    logic [INSTR_W-1:0] r_instr;
    logic [DW-1:0]      r_op_p;
    logic [DW-1:0]      r_op_q;
    logic [DW:0]        r_result;
    logic               r_done;
    logic               r_carry;
    logic               r_zero;

    logic [1:0]         w_op;
    logic [AW-1:0]      w_rd;
    logic [AW-1:0]      w_ra;
    logic [AW-1:0]      w_rb;
    logic [IMM_W-1:0]   w_imm;
    logic [DW:0]        w_alu_result;

    assign w_op  = r_instr[OP_HI:OP_LO];
    assign w_rd  = AW'(r_instr[RD_HI:RD_LO]);
    assign w_ra  = AW'(r_instr[RA_HI:RA_LO]);
    assign w_rb  = AW'(r_instr[RB_HI:RB_LO]);
    assign w_imm = r_instr[IMM_HI:IMM_LO];

    rfs_alu #(
        .DW (DW)
    ) u_alu (
        .op     (w_op),
        .op_p   (r_op_p),
        .op_q   (r_op_q),
        .imm    (w_imm),
        .result (w_alu_result)
    );

    // Sequencer: IDLE -> READ -> EXEC -> WRITE -> IDLE, with instruction,
    // operand, result and flag registers updated as each phase completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_instr  <= '0;
            r_op_p   <= '0;
            r_op_q   <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_instr <= bus.instr;
                        r_state <= READ;
                    end
                end
                READ: begin
                    // Operands are captured here, so RD aliasing RA/RB sees old values
                    r_op_p  <= bus.datap;
                    r_op_q  <= bus.dataq;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_result <= w_alu_result;
                    r_state  <= WRITE;
                end
                WRITE: begin
                    r_zero <= (r_result[DW-1:0] == '0);
                    if (is_arith(w_op)) begin
                        r_carry <= r_result[DW];
                    end
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = r_done;
    assign bus.rp      = w_ra;
    assign bus.rq      = w_rb;
    assign bus.wa      = w_rd;
    // Reset during WRITE cancels the write-back so no partial instruction lands
    assign bus.wr      = (r_state == WRITE) & ~rst;
    assign bus.ld_data = r_result[DW-1:0];
    assign bus.carry   = r_carry;
    assign bus.zero    = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_regfile_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_seq_ctrl
// Description : Self-checking bench for regfile_seq_ctrl. Owns the register
//               file, keeps an instruction-level reference model and checks
//               the sequencer outputs every cycle, plus literal pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_seq_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_seq_ctrl_if #(.DW(4), .AW(3)) bus ();

    regfile_seq_ctrl #(.DW(4), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file driven by the DUT write port
    logic [3:0] rf [8];
    assign bus.datap = rf[bus.rp];
    assign bus.dataq = rf[bus.rq];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   ref_rf [8];
    int   m_age;          // cycles since acceptance, 0 when idle
    bit   m_done;
    bit   m_carry, m_zero;
    int   m_rp, m_rq, m_rd, m_res;
    bit   m_c, m_arith;
    bit   chk_en = 1'b0;

    // Captured write-port activity
    bit         pend_wr = 1'b0;
    logic [2:0] pend_wa;
    logic [3:0] pend_ld;
    logic       cap_wr;
    logic [2:0] last_wa;
    logic [3:0] last_ld;
    int         wr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] mk(input logic [1:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [3:0] lo);
        return {op, rd, ra, lo};
    endfunction

    task automatic compare();
        bit wexp;
        cap_wr = bus.wr;
        if (bus.wr === 1'b1) begin
            pend_wr = 1'b1;
            pend_wa = bus.wa;
            pend_ld = bus.ld_data;
            last_wa = bus.wa;
            last_ld = bus.ld_data;
            wr_cnt++;
        end
        if (!chk_en) return;
        wexp = (m_age == 3) && !rst;
        chk("busy", 32'(bus.busy), 32'(m_age != 0));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("wr", 32'(bus.wr), 32'(wexp));
        if (wexp) begin
            chk("wa", 32'(bus.wa), 32'(m_rd));
            chk("ld_data", 32'(bus.ld_data), 32'(m_res));
        end
        chk("carry", 32'(bus.carry), 32'(m_carry));
        chk("zero", 32'(bus.zero), 32'(m_zero));
        chk("rp", 32'(bus.rp), 32'(m_rp));
        chk("rq", 32'(bus.rq), 32'(m_rq));
    endtask

    task automatic model_edge();
        logic [11:0] ins;
        int p, q, s;
        if (pend_wr) begin
            rf[pend_wa] <= pend_ld;
            pend_wr = 1'b0;
        end
        if (rst) begin
            m_age = 0; m_done = 0; m_carry = 0; m_zero = 0;
            m_rp = 0; m_rq = 0;
            chk_en = 1'b1;
        end else begin
            m_done = (m_age == 3);
            if (m_age == 3) begin
                ref_rf[m_rd] = m_res;
                m_zero = (m_res == 0);
                if (m_arith) m_carry = m_c;
                m_age = 0;
            end else if (m_age != 0) begin
                m_age++;
            end else if (bus.start) begin
                ins   = bus.instr;
                m_rd  = int'(ins[9:7]);
                m_rp  = int'(ins[6:4]);
                m_rq  = int'(ins[2:0]);
                p     = ref_rf[m_rp];
                q     = ref_rf[m_rq];
                m_arith = ins[11];
                m_c   = 1'b0;
                case (ins[11:10])
                    2'b00: m_res = int'(ins[3:0]);
                    2'b01: m_res = p;
                    2'b10: begin s = p + q; m_res = s % 16; m_c = (s > 15); end
                    default: begin m_res = (p - q + 16) % 16; m_c = (p < q); end
                endcase
                m_age = 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic issue(input logic [11:0] ins);
        bus.start = 1'b1;
        bus.instr = ins;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            rf[i] = 4'h0;
            ref_rf[i] = 0;
        end
        m_age = 0; m_done = 0; m_carry = 0; m_zero = 0;
        m_rp = 0; m_rq = 0; m_rd = 0; m_res = 0; m_c = 0; m_arith = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.instr = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_rp", 32'(bus.rp), 0);
        chk("reset_carry", 32'(bus.carry), 0);
        tick();

        // LDI R3 = A
        issue(mk(2'b00, 3'd3, 3'd0, 4'hA));
        chk("ldi_wa", 32'(last_wa), 3);
        chk("ldi_data", 32'(last_ld), 32'hA);
        chk("ldi_done", 32'(bus.done), 1);
        chk("ldi_zero", 32'(bus.zero), 0);
        chk("ldi_carry", 32'(bus.carry), 0);

        // ADD with carry: 9 + 8
        issue(mk(2'b00, 3'd1, 3'd0, 4'h9));
        issue(mk(2'b00, 3'd2, 3'd0, 4'h8));
        issue(mk(2'b10, 3'd4, 3'd1, 4'h2));
        chk("add_data", 32'(last_ld), 1);
        chk("add_carry", 32'(bus.carry), 1);
        chk("add_zero", 32'(bus.zero), 0);
        chk("add_rp", 32'(bus.rp), 1);
        chk("add_rq", 32'(bus.rq), 2);

        // SUB to zero
        issue(mk(2'b11, 3'd5, 3'd1, 4'h1));
        chk("subz_data", 32'(last_ld), 0);
        chk("subz_zero", 32'(bus.zero), 1);
        chk("subz_carry", 32'(bus.carry), 0);

        // Aliased ADD uses old R6
        issue(mk(2'b00, 3'd6, 3'd0, 4'h7));
        issue(mk(2'b10, 3'd6, 3'd6, 4'h6));
        chk("alias_data", 32'(last_ld), 32'hE);

        // SUB with borrow: 3 - 5
        issue(mk(2'b00, 3'd1, 3'd0, 4'h3));
        issue(mk(2'b00, 3'd2, 3'd0, 4'h5));
        issue(mk(2'b11, 3'd7, 3'd1, 4'h2));
        chk("subb_data", 32'(last_ld), 32'hE);
        chk("subb_carry", 32'(bus.carry), 1);

        // MOV leaves carry alone
        issue(mk(2'b01, 3'd0, 3'd6, 4'h0));
        chk("mov_data", 32'(last_ld), 32'hE);
        chk("mov_carry", 32'(bus.carry), 1);

        // Reset during WRITE of LDI R7 = 5
        bus.start = 1'b1;
        bus.instr = mk(2'b00, 3'd7, 3'd0, 4'h5);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_wr_suppressed", 32'(cap_wr), 0);
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        tick();
        chk("rst_r7_kept", 32'(rf[7]), 32'hE);

        // START held high: one instruction every 4 cycles
        wr_cnt = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 48; i++) begin
            bus.instr = 12'($urandom_range(0, 4095));
            tick();
        end
        chk("b2b_wr_count", 32'(wr_cnt), 12);

        // Random traffic with START toggling mid-BUSY and occasional reset
        for (int i = 0; i < 600; i++) begin
            bus.start = ($urandom_range(0, 2) != 0);
            bus.instr = 12'($urandom_range(0, 4095));
            rst       = ($urandom_range(0, 59) == 0);
            tick();
        end
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (6) tick();

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rf_final_%0d", i), 32'(rf[i]), 32'(ref_rf[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
